// File: rtl/uart_pkg.sv
// Shared UART baud-generator types, default widths and the divisor clamp helper.
package uart_pkg;

   localparam int UART_OSR_DEF = 16;
   localparam int UART_DIV_W   = 16;
   localparam int UART_FRAC_W  = 4;

   typedef struct packed {
      logic [UART_DIV_W-1:0]  div_int;
      logic [UART_FRAC_W-1:0] div_frac;
   } baud_cfg_t;

   // Below 2 the divider would tick on back-to-back cycles.
   function automatic logic [UART_DIV_W-1:0] uart_clamp_div(input logic [UART_DIV_W-1:0] d);
      return (d < UART_DIV_W'(2)) ? UART_DIV_W'(2) : d;
   endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: one-cycle os_tick with average period div_int + div_frac/2^FRAC_W clk.
module uart_frac_div
   import uart_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en_i,
   input  logic      restart_i,
   input  logic      apply_i,
   input  baud_cfg_t cfg_i,
   output logic      tick_pre_o,
   output logic      os_tick_o
);

   localparam int CNT_W = UART_DIV_W + 1;

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [UART_FRAC_W-1:0] acc_q, acc_d;
   logic                   os_tick_q, os_tick_d;
   logic [CNT_W-1:0]       base;
   logic [UART_FRAC_W:0]   sum;

   assign base      = {1'b0, uart_clamp_div(cfg_i.div_int)};
   assign sum       = {1'b0, acc_q} + {1'b0, cfg_i.div_frac};
   assign os_tick_d = en_i && !restart_i && (cnt_q == CNT_W'(1));

   // cnt == 0 only right after enable; cnt == 1 is the last cycle of a period.
   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (!en_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (restart_i) begin
         cnt_d = base;
         acc_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = base;
      end else if (cnt_q == CNT_W'(1)) begin
         if (apply_i) begin
            cnt_d = base;
            acc_d = '0;
         end else begin
            cnt_d = base + CNT_W'(sum[UART_FRAC_W]);
            acc_d = sum[UART_FRAC_W-1:0];
         end
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         os_tick_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         os_tick_q <= os_tick_d;
      end
   end

   assign tick_pre_o = os_tick_d;
   assign os_tick_o  = os_tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample tick, bit-centre/bit-boundary ticks, baud clock and
// a shadowed divisor that only takes effect on a bit boundary, a resync or while idle.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W        = UART_DIV_W,
   parameter int FRAC_W       = UART_FRAC_W,
   parameter int OSR          = UART_OSR_DEF,
   parameter int DEF_DIV_INT  = 54,
   parameter int DEF_DIV_FRAC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              resync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIV_W-1:0]  cfg_div_int,
   input  logic [FRAC_W-1:0] cfg_div_frac,
   output logic              cfg_pending,
   output logic              os_tick,
   output logic              mid_tick,
   output logic              baud_tick,
   output logic              baud_clk
);

   localparam int OS_W = $clog2(OSR);
   localparam baud_cfg_t DEF_CFG = '{div_int:  UART_DIV_W'(DEF_DIV_INT),
                                     div_frac: UART_FRAC_W'(DEF_DIV_FRAC)};

   logic [OS_W-1:0] os_cnt_q, os_cnt_d;
   logic            mid_q, mid_d;
   logic            baud_q, baud_d;
   logic            bclk_q, bclk_d;
   logic            pend_q, pend_d;
   logic            ready_q, ready_d;
   baud_cfg_t       shadow_q, shadow_d;
   baud_cfg_t       active_q, active_d;
   baud_cfg_t       cfg_in;
   logic            restart, accept, apply, tick_pre;

   assign restart = en && resync;
   assign accept  = cfg_valid && ready_q;
   assign cfg_in  = '{div_int: UART_DIV_W'(cfg_div_int), div_frac: UART_FRAC_W'(cfg_div_frac)};
   assign baud_d  = tick_pre && (os_cnt_q == OS_W'(OSR - 1));
   assign mid_d   = tick_pre && (os_cnt_q == OS_W'(OSR/2 - 1));
   assign apply   = pend_q && (!en || restart || baud_d);

   // The divider is fed the next-state divisor so a period starting on an apply edge uses it.
   uart_frac_div u_frac_div (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .restart_i  (restart),
      .apply_i    (apply),
      .cfg_i      (active_d),
      .tick_pre_o (tick_pre),
      .os_tick_o  (os_tick)
   );

   always_comb begin
      os_cnt_d = os_cnt_q;
      if (!en || restart) begin
         os_cnt_d = '0;
      end else if (tick_pre) begin
         os_cnt_d = (os_cnt_q == OS_W'(OSR - 1)) ? '0 : os_cnt_q + OS_W'(1);
      end
      bclk_d = (os_cnt_d >= OS_W'(OSR/2));
   end

   // accept and apply are exclusive: accept needs ready, apply needs pending.
   always_comb begin
      active_d = active_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (apply) begin
         active_d = shadow_q;
         pend_d   = 1'b0;
      end
      if (accept) begin
         if (en) begin
            shadow_d = cfg_in;
            pend_d   = 1'b1;
         end else begin
            active_d = cfg_in;
         end
      end
      ready_d = !pend_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         os_cnt_q <= '0;
         mid_q    <= 1'b0;
         baud_q   <= 1'b0;
         bclk_q   <= 1'b0;
         pend_q   <= 1'b0;
         ready_q  <= 1'b1;
         shadow_q <= DEF_CFG;
         active_q <= DEF_CFG;
      end else begin
         os_cnt_q <= os_cnt_d;
         mid_q    <= mid_d;
         baud_q   <= baud_d;
         bclk_q   <= bclk_d;
         pend_q   <= pend_d;
         ready_q  <= ready_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign mid_tick    = mid_q;
   assign baud_tick   = baud_q;
   assign baud_clk    = bclk_q;
   assign cfg_pending = pend_q;
   assign cfg_ready   = ready_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: tick spacing, config handshake, resync, clamp, idle and async reset.
module tb_uart_baud_gen;

   localparam int S_OS   = 0;
   localparam int S_MID  = 1;
   localparam int S_BAUD = 2;
   localparam int S_BCLK = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        resync = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div_int = '0;
   logic [3:0]  cfg_div_frac = '0;
   logic        cfg_ready, cfg_pending, os_tick, mid_tick, baud_tick, baud_clk;

   int n_cmp = 0;
   int n_mis = 0;

   uart_baud_gen dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .resync       (resync),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_div_int  (cfg_div_int),
      .cfg_div_frac (cfg_div_frac),
      .cfg_pending  (cfg_pending),
      .os_tick      (os_tick),
      .mid_tick     (mid_tick),
      .baud_tick    (baud_tick),
      .baud_clk     (baud_clk)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel_sig(input int s);
      logic v;
      case (s)
         S_OS:    v = os_tick;
         S_MID:   v = mid_tick;
         S_BAUD:  v = baud_tick;
         default: v = baud_clk;
      endcase
      return v;
   endfunction

   // Edges until the selected output reaches lvl; -1 if the budget runs out.
   task automatic wait_sig(input int s, input logic lvl, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (sel_sig(s) === lvl) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int   n, ticks, consec, hot;
      logic prev;

      repeat (3) step();
      chk("rst_os", os_tick, 0);
      chk("rst_mid", mid_tick, 0);
      chk("rst_baud", baud_tick, 0);
      chk("rst_bclk", baud_clk, 0);
      chk("rst_pend", cfg_pending, 0);
      chk("rst_ready", cfg_ready, 1);
      rst = 1'b0;
      step();

      // Default 54 + 4/16 divisor.
      en = 1'b1;
      step();
      wait_sig(S_OS, 1'b1, 200, n);
      chk("first_os_def", n, 54);
      for (int p = 1; p <= 15; p++) begin
         wait_sig(S_OS, 1'b1, 200, n);
         chk("os_per_def", n, (p % 4 == 0) ? 55 : 54);
         chk("mid_pos_def", mid_tick, (p + 1 == 8) ? 1 : 0);
         chk("baud_pos_def", baud_tick, (p + 1 == 16) ? 1 : 0);
      end
      wait_sig(S_BAUD, 1'b1, 1000, n);
      chk("baud_per_def", n, 868);

      // Divisor 10/0 offered while running waits for the next bit boundary.
      cfg_div_int  = 16'd10;
      cfg_div_frac = 4'd0;
      cfg_valid    = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("pend_set", cfg_pending, 1);
      chk("ready_low", cfg_ready, 0);
      repeat (400) step();
      chk("pend_hold", cfg_pending, 1);
      wait_sig(S_BAUD, 1'b1, 1000, n);
      chk("baud_apply", n, 467);
      chk("pend_clr", cfg_pending, 0);
      chk("ready_back", cfg_ready, 1);
      for (int p = 0; p < 3; p++) begin
         wait_sig(S_OS, 1'b1, 50, n);
         chk("os_per_10", n, 10);
      end
      wait_sig(S_BAUD, 1'b1, 300, n);
      chk("baud_rem_10", n, 130);
      wait_sig(S_BCLK, 1'b1, 300, n);
      chk("bclk_low_10", n, 80);
      chk("mid_at_rise", mid_tick, 1);
      wait_sig(S_BCLK, 1'b0, 300, n);
      chk("bclk_high_10", n, 80);
      chk("baud_at_fall", baud_tick, 1);

      // Resync on the very edge an os_tick was due.
      for (int p = 0; p < 3; p++) begin
         wait_sig(S_OS, 1'b1, 50, n);
         chk("os_per_pre_rs", n, 10);
      end
      repeat (9) step();
      resync = 1'b1;
      step();
      resync = 1'b0;
      chk("rs_no_os", os_tick, 0);
      chk("rs_no_mid", mid_tick, 0);
      chk("rs_no_baud", baud_tick, 0);
      wait_sig(S_MID, 1'b1, 300, n);
      chk("rs_mid", n, 80);
      wait_sig(S_BAUD, 1'b1, 300, n);
      chk("rs_baud", n, 80);

      // Divisors 0 and 1 clamp to a 2-cycle period.
      for (int d = 0; d < 2; d++) begin
         en = 1'b0;
         step();
         cfg_div_int  = 16'(d);
         cfg_div_frac = 4'd0;
         cfg_valid    = 1'b1;
         step();
         cfg_valid = 1'b0;
         chk("ready_idle_min", cfg_ready, 1);
         chk("pend_idle_min", cfg_pending, 0);
         en = 1'b1;
         step();
         wait_sig(S_OS, 1'b1, 20, n);
         chk("first_os_min", n, 2);
         ticks  = 0;
         consec = 0;
         prev   = os_tick;
         repeat (40) begin
            step();
            if (os_tick) ticks++;
            if (prev && os_tick) consec++;
            prev = os_tick;
         end
         chk("ticks_min", ticks, 20);
         chk("consec_min", consec, 0);
      end

      // Drop en mid-bit with baud_clk high, then program 20/8 while idle.
      wait_sig(S_BCLK, 1'b1, 100, n);
      chk("bclk_rise_min", n, 6);
      en = 1'b0;
      step();
      chk("off_os", os_tick, 0);
      chk("off_mid", mid_tick, 0);
      chk("off_baud", baud_tick, 0);
      chk("off_bclk", baud_clk, 0);
      cfg_div_int  = 16'd20;
      cfg_div_frac = 4'd8;
      cfg_valid    = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("ready_idle", cfg_ready, 1);
      chk("pend_idle", cfg_pending, 0);
      hot = 0;
      repeat (30) begin
         step();
         if (os_tick || mid_tick || baud_tick || baud_clk) hot++;
      end
      chk("idle_quiet", hot, 0);
      en = 1'b1;
      step();
      wait_sig(S_OS, 1'b1, 100, n);
      chk("first_os_20", n, 20);
      for (int p = 1; p <= 6; p++) begin
         wait_sig(S_OS, 1'b1, 100, n);
         chk("os_per_20_8", n, (p % 2 == 1) ? 20 : 21);
      end

      // Asynchronous reset while a divisor is pending.
      cfg_div_int  = 16'd10;
      cfg_div_frac = 4'd0;
      cfg_valid    = 1'b1;
      step();
      cfg_valid = 1'b0;
      repeat (3) step();
      chk("pend_pre_rst", cfg_pending, 1);
      chk("ready_pre_rst", cfg_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_pend", cfg_pending, 0);
      chk("arst_ready", cfg_ready, 1);
      chk("arst_os", os_tick, 0);
      chk("arst_bclk", baud_clk, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      wait_sig(S_OS, 1'b1, 200, n);
      chk("first_os_post_rst", n, 54);
      for (int p = 1; p <= 8; p++) begin
         wait_sig(S_OS, 1'b1, 200, n);
         chk("os_per_post_rst", n, (p % 4 == 0) ? 55 : 54);
      end
      chk("pend_lost", cfg_pending, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
